// File: rtl/banco_registros_param.sv
// banco_registros_param
// Parametrised register bank with two combinational read ports, one
// synchronous write port, an optional hardwired-zero R0, an optional
// write-to-read bypass and a shadow bank for single-cycle context
// save/restore on interrupt entry and exit.
//
// Ports
//   Clk          in   system clock, rising edge
//   Rst          in   asynchronous reset, active-low
//   Dat          in   write data (DATA_W)
//   RegX, RegY   in   read addresses for operand ports X and Y (ADDR_W)
//   R_W          in   write address (ADDR_W)
//   E_N          in   write enable, active-high
//   Save         in   copy live bank into shadow bank (level-sampled)
//   Restore      in   copy shadow bank into live bank (level-sampled)
//   RX, RY       out  combinational read data (DATA_W)
//   Shadow_Valid out  shadow bank holds a saved context
//   Err          out  registered one-cycle pulse on an illegal Save/Restore
module banco_registros_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] Dat,
  input  logic [ADDR_W-1:0] RegX,
  input  logic [ADDR_W-1:0] RegY,
  input  logic [ADDR_W-1:0] R_W,
  input  logic              E_N,
  input  logic              Save,
  input  logic              Restore,
  output logic [DATA_W-1:0] RX,
  output logic [DATA_W-1:0] RY,
  output logic              Shadow_Valid,
  output logic              Err
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] bank   [NREG];
  logic [DATA_W-1:0] shadow [NREG];
  logic              shadow_valid_q;
  logic              err_q;

  logic save_req;
  logic restore_req;
  logic do_restore;
  logic err_d;
  logic write_ok;

  // Save and Restore together cancel each other out and are flagged.
  assign save_req    = Save & ~Restore;
  assign restore_req = Restore & ~Save;
  assign do_restore  = restore_req & shadow_valid_q;
  assign err_d       = (Save & Restore) | (restore_req & ~shadow_valid_q);
  assign write_ok    = E_N & ~(ZERO_R0 && (R_W == '0));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NREG; i++) begin
        bank[i]   <= '0;
        shadow[i] <= '0;
      end
      shadow_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        // A concurrent write takes priority over the restored value.
        if (write_ok && (R_W == ADDR_W'(i))) begin
          bank[i] <= Dat;
        end else if (do_restore) begin
          bank[i] <= shadow[i];
        end
        // Shadow captures the pre-write contents of the live bank.
        if (save_req) begin
          shadow[i] <= bank[i];
        end
      end
      if (save_req) begin
        shadow_valid_q <= 1'b1;
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    RX = bank[RegX];
    if (BYPASS && E_N && (R_W == RegX)) begin
      RX = Dat;
    end
    if (ZERO_R0 && (RegX == '0)) begin
      RX = '0;
    end
  end

  always_comb begin
    RY = bank[RegY];
    if (BYPASS && E_N && (R_W == RegY)) begin
      RY = Dat;
    end
    if (ZERO_R0 && (RegY == '0)) begin
      RY = '0;
    end
  end

  assign Shadow_Valid = shadow_valid_q;
  assign Err          = err_q;

endmodule
